// File: rtl/jtpang_objdma.sv
// Object RAM DMA: takes the CPU bus, copies 2^AW bytes of work RAM into the
// object buffer, then hands the bus back. Requests arriving mid-transfer queue one copy.
module jtpang_objdma #(
  parameter int AW = 9
) (
  input  logic          rst,
  input  logic          clk,
  input  logic          cen,
  input  logic          dma_go,
  input  logic          busak_n,
  output logic          busrq,
  output logic [AW-1:0] dma_addr,
  input  logic [7:0]    dma_din,
  output logic [AW-1:0] obj_addr,
  output logic [7:0]    obj_dout,
  output logic          obj_we,
  output logic          busy
);

  typedef enum logic [1:0] {IDLE, REQ, COPY, REL} st_t;

  st_t  st;
  logic pend;
  logic first;   // first COPY cycle only presents address 0; its data lands next cycle

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st       <= IDLE;
      busrq    <= 1'b0;
      busy     <= 1'b0;
      pend     <= 1'b0;
      first    <= 1'b0;
      dma_addr <= '0;
      obj_addr <= '0;
      obj_dout <= '0;
      obj_we   <= 1'b0;
    end else begin
      obj_we <= 1'b0;
      if (cen) begin
        if (dma_go && st != IDLE) pend <= 1'b1;
        case (st)
          IDLE: if (dma_go) begin
            st    <= REQ;
            busrq <= 1'b1;
            busy  <= 1'b1;
          end
          REQ: if (!busak_n) begin
            st       <= COPY;
            dma_addr <= '0;
            first    <= 1'b1;
          end
          COPY: if (!busak_n) begin
            if (first) begin
              first <= 1'b0;
            end else begin
              obj_we   <= 1'b1;
              obj_addr <= dma_addr;
              obj_dout <= dma_din;
              dma_addr <= dma_addr + AW'(1);
              if (&dma_addr) begin
                st    <= REL;
                busrq <= 1'b0;
              end
            end
          end
          REL: if (busak_n) begin
            // a queued (or still-held) request restarts without passing through IDLE
            if (pend || dma_go) begin
              st    <= REQ;
              busrq <= 1'b1;
              pend  <= 1'b0;
            end else begin
              st   <= IDLE;
              busy <= 1'b0;
            end
          end
          default: st <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_jtpang_objdma.sv
// Bench for jtpang_objdma: bus-arbiter and work-RAM model around the DMA,
// each copy checked as a whole transaction against the source memory.
module tb_jtpang_objdma;
  localparam int AW = 9;
  localparam int N  = 1 << AW;

  logic          clk = 1'b0;
  logic          rst, cen, dma_go, busak_n;
  logic          busrq, obj_we, busy;
  logic [AW-1:0] dma_addr, obj_addr;
  logic [7:0]    dma_din, obj_dout;
  logic [7:0]    mem [N];

  assign dma_din = mem[dma_addr];

  jtpang_objdma #(.AW(AW)) dut (
    .rst(rst), .clk(clk), .cen(cen), .dma_go(dma_go), .busak_n(busak_n),
    .busrq(busrq), .dma_addr(dma_addr), .dma_din(dma_din),
    .obj_addr(obj_addr), .obj_dout(obj_dout), .obj_we(obj_we), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_err = 0;
  int tcount = 0, t_copy = 0, t_fall = 0, last_gap = 0;
  int we_bad = 0, stall_bad = 0, rel_bad = 0;
  int n_rise = 0, n_bfall = 0, copies = 0;
  int rq_age = 0, stall_left = 0, stall_at = -1, cen_mode = 0;
  bit rnd_stall = 0, copying = 0, rq_p = 0, busy_p = 0, cen_q = 0, bak_q = 1;
  logic [16:0] wq [$];
  int durs [$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic fill(input bit rnd);
    for (int i = 0; i < N; i++) mem[i] = rnd ? 8'($urandom) : 8'(i);
  endtask

  // one finished copy must be exactly addresses 0..N-1 in order with source data
  task automatic check_copy();
    int bad = 0;
    chk("wr_count", wq.size(), N);
    for (int i = 0; i < wq.size() && i < N; i++)
      if (wq[i] !== {AW'(i), mem[i]}) bad++;
    chk("wr_data", bad, 0);
    chk("last_wr", {obj_we, obj_addr}, {1'b1, AW'(N-1)});
    wq.delete();
    copies++;
  endtask

  task automatic tick();
    @(posedge clk);
    cen_q = cen; bak_q = busak_n;
    #1;
    tcount++;
    if (!rst) begin
      if (obj_we) begin
        if (!cen_q) we_bad++;
        if (bak_q)  stall_bad++;
        wq.push_back({obj_addr, obj_dout});
      end
      if (busrq && !rq_p) begin n_rise++; last_gap = tcount - t_fall; end
      if (busrq && rq_p && !copying && cen_q && !bak_q) begin copying = 1; t_copy = tcount; end
      if (!busrq && rq_p) begin
        copying = 0; t_fall = tcount;
        durs.push_back(tcount - t_copy);
        check_copy();
      end
      if (!busy && busy_p) begin n_bfall++; if (!bak_q) rel_bad++; end
    end
    rq_p = busrq; busy_p = busy;
    // bus arbiter: grant two cycles after request, release as soon as it drops
    if (busrq) rq_age++; else rq_age = 0;
    if (copying && stall_at >= 0 && int'(dma_addr) == stall_at && !busak_n) begin
      stall_left = 10; stall_at = -1;
    end
    if (rnd_stall && copying && stall_left == 0 && $urandom_range(49) == 0)
      stall_left = 1 + $urandom_range(4);
    busak_n = (busrq && rq_age >= 2 && stall_left == 0) ? 1'b0 : 1'b1;
    if (stall_left > 0) stall_left--;
    case (cen_mode)
      0:       cen = 1'b1;
      1:       cen = ~cen;
      default: cen = ($urandom_range(2) != 0);
    endcase
  endtask

  task automatic pulse_go();
    dma_go = 1'b1;
    do tick(); while (!cen_q);
    dma_go = 1'b0;
  endtask

  task automatic wait_addr(input int a);
    int n = 0;
    while (!(copying && int'(dma_addr) == a) && n < 5000) begin tick(); n++; end
    chk("reach_addr", n < 5000, 1);
  endtask

  task automatic run_done(input string tag);
    int n = 0;
    while (busy && n < 8000) begin tick(); n++; end
    chk(tag, busy, 0);
    repeat (4) tick();
  endtask

  initial begin
    int c0, b0, n;
    rst = 1'b1; cen = 1'b1; dma_go = 1'b0; busak_n = 1'b1;
    fill(0);
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busrq", busrq, 0);
    chk("rst_busy", busy, 0);
    chk("rst_we", obj_we, 0);
    chk("rst_dma_addr", dma_addr, 0);
    chk("rst_obj_addr", obj_addr, 0);
    chk("rst_obj_dout", obj_dout, 0);
    rst = 1'b0;
    repeat (3) tick();
    chk("idle_no_req", busrq, 0);

    // single copy, full-rate cen, source byte = address
    c0 = copies; b0 = n_bfall;
    pulse_go();
    chk("go_busrq", busrq, 1);
    chk("go_busy", busy, 1);
    run_done("done_basic");
    chk("basic_copies", copies - c0, 1);
    chk("basic_dur", durs[$], N + 1);
    chk("basic_bfall", n_bfall - b0, 1);

    // 10-cycle bus stall at dma_addr 100
    fill(1);
    c0 = copies; stall_at = 100;
    pulse_go();
    run_done("done_stall");
    chk("stall_copies", copies - c0, 1);
    chk("stall_dur", durs[$], N + 11);
    chk("stall_no_wr", stall_bad, 0);

    // three requests during a copy merge into one extra copy
    c0 = copies; b0 = n_bfall;
    pulse_go();
    wait_addr(50);  pulse_go();
    wait_addr(200); pulse_go();
    wait_addr(300); pulse_go();
    run_done("done_merge");
    chk("merge_copies", copies - c0, 2);
    chk("merge_busy_once", n_bfall - b0, 1);
    chk("merge_rel_gap", last_gap, 1);

    // reset in the middle of a copy, with a request already queued
    pulse_go();
    wait_addr(10); pulse_go();
    n = 0;
    while (!(obj_we && obj_addr == AW'(37)) && n < 2000) begin tick(); n++; end
    chk("reach_37", n < 2000, 1);
    rst = 1'b1;
    #1;
    chk("mid_rst_busrq", busrq, 0);
    chk("mid_rst_we", obj_we, 0);
    chk("mid_rst_busy", busy, 0);
    wq.delete(); copying = 0;
    repeat (3) tick();
    rst = 1'b0;
    repeat (60) tick();
    chk("post_rst_wr", wq.size(), 0);
    chk("post_rst_busrq", busrq, 0);
    chk("post_rst_busy", busy, 0);

    // half-rate cen
    fill(0);
    cen_mode = 1; c0 = copies;
    pulse_go();
    run_done("done_half");
    chk("half_copies", copies - c0, 1);
    chk("half_dur", durs[$], 2 * (N + 1));

    // held request, random cen and random stalls: back-to-back copies
    fill(1);
    cen_mode = 2; rnd_stall = 1; c0 = copies; b0 = n_bfall;
    dma_go = 1'b1;
    n = 0;
    while (copies == c0 && n < 8000) begin tick(); n++; end
    dma_go = 1'b0;
    run_done("done_level");
    chk("level_copies", copies - c0, 2);
    chk("level_no_idle", n_bfall - b0, 1);

    chk("we_on_cen", we_bad, 0);
    chk("no_wr_stalled", stall_bad, 0);
    chk("busy_after_release", rel_bad, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end
endmodule
